// File: rtl/pn_checker.sv
// PN sequence checker: decodes NRZ-L/M/S with optional inversion, self-synchronises a
// local Fibonacci LFSR to the incoming PN stream, then measures bit errors over a
// programmable window while locked.
module pn_checker #(
  parameter int unsigned MAX_LEN = 24,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_bit_en,
  input  logic               i_rx_bit,
  input  logic [MAX_LEN-1:0] i_poly_taps,
  input  logic [4:0]         i_poly_length,
  input  logic [1:0]         i_pcm_mode,
  input  logic               i_pcm_invert,
  input  logic               i_restart,
  input  logic [7:0]         i_lock_thresh,
  input  logic [CNT_W-1:0]   i_loss_thresh,
  input  logic [CNT_W-1:0]   i_window_bits,
  output logic               o_locked,
  output logic               o_err_pulse,
  output logic               o_window_done,
  output logic [CNT_W-1:0]   o_win_bits,
  output logic [CNT_W-1:0]   o_win_errs
);

  typedef enum logic [1:0] {
    StSearch,
    StVerify,
    StLocked
  } state_e;

  // Stage 1 registers
  logic               r_prev_rx;
  logic               r_d;
  logic               r_d_en;

  // Stage 2 registers
  state_e             r_state;
  logic [MAX_LEN-1:0] r_lfsr;
  logic [4:0]         r_fill;
  logic [7:0]         r_match_cnt;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [CNT_W-1:0]   r_err_cnt;
  logic               r_err_pulse;
  logic               r_window_done;
  logic [CNT_W-1:0]   r_win_bits;
  logic [CNT_W-1:0]   r_win_errs;

  // Next-state wires
  state_e             w_state_nxt;
  logic [MAX_LEN-1:0] w_lfsr_nxt;
  logic [4:0]         w_fill_nxt;
  logic [7:0]         w_match_cnt_nxt;
  logic [CNT_W-1:0]   w_bit_cnt_nxt;
  logic [CNT_W-1:0]   w_err_cnt_nxt;
  logic               w_err_pulse_nxt;
  logic               w_window_done_nxt;
  logic [CNT_W-1:0]   w_win_bits_nxt;
  logic [CNT_W-1:0]   w_win_errs_nxt;

  // Datapath wires
  logic               w_dec;
  logic [MAX_LEN-1:0] w_len_mask;
  logic               w_pred;
  logic               w_err;
  logic               w_new_bit;
  logic [CNT_W:0]     w_err_sum;
  logic [CNT_W-1:0]   w_err_sat;
  logic [CNT_W:0]     w_bit_inc;
  logic [CNT_W-1:0]   w_bit_sat;
  logic               w_win_end;
  logic               w_loss;
  logic [7:0]         w_lock_eff;
  logic [8:0]         w_match_inc;
  logic               w_lock_hit;
  logic               w_fill_done;

  // Line decode: NRZ-M marks a 1 with a transition, NRZ-S marks a 0 with one
  always_comb begin
    w_dec = i_rx_bit;
    case (i_pcm_mode)
      2'd1:    w_dec = i_rx_bit ^ r_prev_rx;
      2'd2:    w_dec = ~(i_rx_bit ^ r_prev_rx);
      default: w_dec = i_rx_bit;
    endcase
    w_dec = w_dec ^ i_pcm_invert;
  end

  // Stage 1 register: decoded bit and its valid strobe
  always_ff @(posedge clk) begin
    if (reset || i_restart) begin
      r_prev_rx <= 1'b0;
      r_d       <= 1'b0;
      r_d_en    <= 1'b0;
    end else begin
      r_d_en <= i_bit_en;
      if (i_bit_en) begin
        r_prev_rx <= i_rx_bit;
        r_d       <= w_dec;
      end
    end
  end

  // Mask of the N active LFSR stages
  always_comb begin
    w_len_mask = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      w_len_mask[k] = (5'(k) < i_poly_length);
    end
  end

  // Prediction, error and saturating counter arithmetic
  always_comb begin
    w_pred      = ^(r_lfsr & i_poly_taps & w_len_mask);
    w_err       = r_d ^ w_pred;
    w_err_sum   = {1'b0, r_err_cnt} + {{CNT_W{1'b0}}, w_err};
    w_err_sat   = w_err_sum[CNT_W] ? {CNT_W{1'b1}} : w_err_sum[CNT_W-1:0];
    w_bit_inc   = {1'b0, r_bit_cnt} + {{CNT_W{1'b0}}, 1'b1};
    w_bit_sat   = w_bit_inc[CNT_W] ? {CNT_W{1'b1}} : w_bit_inc[CNT_W-1:0];
    w_win_end   = (i_window_bits != '0) && (w_bit_inc == {1'b0, i_window_bits});
    w_loss      = w_err_sum > {1'b0, i_loss_thresh};
    w_lock_eff  = (i_lock_thresh == 8'd0) ? 8'd1 : i_lock_thresh;
    w_match_inc = {1'b0, r_match_cnt} + 9'd1;
    w_lock_hit  = w_match_inc >= {1'b0, w_lock_eff};
    w_fill_done = r_fill >= (i_poly_length - 5'd1);
  end

  // Stage 2 next-state: search/verify/locked sequencing and window accounting
  always_comb begin
    w_state_nxt       = r_state;
    w_lfsr_nxt        = r_lfsr;
    w_fill_nxt        = r_fill;
    w_match_cnt_nxt   = r_match_cnt;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_err_cnt_nxt     = r_err_cnt;
    w_err_pulse_nxt   = 1'b0;
    w_window_done_nxt = 1'b0;
    w_win_bits_nxt    = r_win_bits;
    w_win_errs_nxt    = r_win_errs;
    w_new_bit         = w_pred;

    if (r_d_en) begin
      case (r_state)
        StSearch: begin
          // Load received bits straight into the LFSR until N stages are filled
          w_new_bit = r_d;
          if (w_fill_done) begin
            w_state_nxt     = StVerify;
            w_match_cnt_nxt = 8'd0;
          end else begin
            w_fill_nxt = r_fill + 5'd1;
          end
        end
        StVerify: begin
          if (w_err) begin
            w_state_nxt     = StSearch;
            w_fill_nxt      = 5'd0;
            w_err_pulse_nxt = 1'b1;
          end else begin
            w_match_cnt_nxt = w_match_inc[7:0];
            if (w_lock_hit) begin
              w_state_nxt   = StLocked;
              w_bit_cnt_nxt = '0;
              w_err_cnt_nxt = '0;
            end
          end
        end
        StLocked: begin
          w_err_pulse_nxt = w_err;
          if (w_win_end) begin
            // Current bit belongs to the closing window
            w_win_bits_nxt    = i_window_bits;
            w_win_errs_nxt    = w_err_sat;
            w_window_done_nxt = 1'b1;
            w_bit_cnt_nxt     = '0;
            w_err_cnt_nxt     = '0;
            if (w_loss) begin
              w_state_nxt = StSearch;
              w_fill_nxt  = 5'd0;
            end
          end else begin
            w_bit_cnt_nxt = w_bit_sat;
            w_err_cnt_nxt = w_err_sat;
          end
        end
        default: begin
          w_state_nxt = StSearch;
          w_fill_nxt  = 5'd0;
        end
      endcase
      w_lfsr_nxt = {r_lfsr[MAX_LEN-2:0], w_new_bit} & w_len_mask;
    end
  end

  // Stage 2 state register; restart behaves like reset without touching config
  always_ff @(posedge clk) begin
    if (reset || i_restart) begin
      r_state       <= StSearch;
      r_lfsr        <= '0;
      r_fill        <= 5'd0;
      r_match_cnt   <= 8'd0;
      r_bit_cnt     <= '0;
      r_err_cnt     <= '0;
      r_err_pulse   <= 1'b0;
      r_window_done <= 1'b0;
      r_win_bits    <= '0;
      r_win_errs    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_lfsr        <= w_lfsr_nxt;
      r_fill        <= w_fill_nxt;
      r_match_cnt   <= w_match_cnt_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_err_cnt     <= w_err_cnt_nxt;
      r_err_pulse   <= w_err_pulse_nxt;
      r_window_done <= w_window_done_nxt;
      r_win_bits    <= w_win_bits_nxt;
      r_win_errs    <= w_win_errs_nxt;
    end
  end

  assign o_locked      = (r_state == StLocked);
  assign o_err_pulse   = r_err_pulse;
  assign o_window_done = r_window_done;
  assign o_win_bits    = r_win_bits;
  assign o_win_errs    = r_win_errs;

endmodule

// File: tb/tb_pn_checker.sv
// Bench for pn_checker: a bit-level PN source drives the checker while a behavioural
// model (sequence history + per-bit rules) predicts every output on every cycle.
module tb_pn_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        bit_en;
  logic        rx_bit;
  logic [23:0] poly_taps;
  logic [4:0]  poly_length;
  logic [1:0]  pcm_mode;
  logic        pcm_invert;
  logic        restart;
  logic [7:0]  lock_thresh;
  logic [31:0] loss_thresh;
  logic [31:0] window_bits;
  logic        locked;
  logic        err_pulse;
  logic        window_done;
  logic [31:0] win_bits;
  logic [31:0] win_errs;

  always #5 clk = ~clk;

  pn_checker #(
    .MAX_LEN(24),
    .CNT_W  (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_bit_en     (bit_en),
    .i_rx_bit     (rx_bit),
    .i_poly_taps  (poly_taps),
    .i_poly_length(poly_length),
    .i_pcm_mode   (pcm_mode),
    .i_pcm_invert (pcm_invert),
    .i_restart    (restart),
    .i_lock_thresh(lock_thresh),
    .i_loss_thresh(loss_thresh),
    .i_window_bits(window_bits),
    .o_locked     (locked),
    .o_err_pulse  (err_pulse),
    .o_window_done(window_done),
    .o_win_bits   (win_bits),
    .o_win_errs   (win_errs)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  int     m_mode;     // 0 search, 1 verify, 2 locked
  bit     m_hist[$];  // local sequence, newest first
  int     m_fill;
  int     m_match;
  longint m_bits;
  longint m_errs;
  bit     m_prev;
  bit     m_pv;
  bit     m_pbit;
  bit     e_locked, e_err, e_done;
  longint e_wb, e_we;

  // Observations of the DUT for literal end-of-test checks
  int     n_err_obs, n_done;
  longint last_wb, last_we;
  bit     locked_at_done, locked_before_done, prev_locked;

  // Source state
  bit g_hist[$];
  bit g_prev_tx;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit m_predict();
    bit p = 1'b0;
    for (int k = 0; k < int'(poly_length); k++) begin
      if (poly_taps[k] && k < m_hist.size()) p ^= m_hist[k];
    end
    return p;
  endfunction

  task automatic m_push(input bit b);
    m_hist.push_front(b);
    if (m_hist.size() > 24) void'(m_hist.pop_back());
  endtask

  task automatic m_clear();
    m_mode = 0; m_hist.delete(); m_fill = 0; m_match = 0; m_bits = 0; m_errs = 0;
    m_prev = 0; m_pv = 0; m_pbit = 0;
    e_err = 0; e_done = 0; e_wb = 0; e_we = 0;
  endtask

  task automatic m_process(input bit d);
    bit p = m_predict();
    bit e = d ^ p;
    int lt = (lock_thresh == 0) ? 1 : int'(lock_thresh);
    if (m_mode == 0) begin
      m_push(d);
      m_fill++;
      if (m_fill >= int'(poly_length)) begin
        m_mode = 1;
        m_match = 0;
      end
    end else if (m_mode == 1) begin
      m_push(p);
      if (e) begin
        m_mode = 0; m_fill = 0; e_err = 1;
      end else begin
        m_match++;
        if (m_match >= lt) begin
          m_mode = 2; m_bits = 0; m_errs = 0;
        end
      end
    end else begin
      m_push(p);
      e_err = e;
      m_bits++;
      m_errs += e;
      if (m_bits > 64'hFFFF_FFFF) m_bits = 64'hFFFF_FFFF;
      if (m_errs > 64'hFFFF_FFFF) m_errs = 64'hFFFF_FFFF;
      if (window_bits != 0 && m_bits == longint'(window_bits)) begin
        e_wb = window_bits; e_we = m_errs; e_done = 1;
        if (m_errs > longint'(loss_thresh)) begin
          m_mode = 0; m_fill = 0;
        end
        m_bits = 0; m_errs = 0;
      end
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare on the falling edge
  task automatic step(input logic be, input logic rx, input logic rs);
    bit d;
    bit_en = be; rx_bit = rx; restart = rs;
    @(posedge clk);
    e_err = 0; e_done = 0;
    if (reset || rs) begin
      m_clear();
    end else begin
      if (m_pv) m_process(m_pbit);
      m_pv = be;
      if (be) begin
        case (pcm_mode)
          2'd1:    d = rx ^ m_prev;
          2'd2:    d = ~(rx ^ m_prev);
          default: d = rx;
        endcase
        m_pbit = d ^ pcm_invert;
        m_prev = rx;
      end
    end
    e_locked = (m_mode == 2);
    @(negedge clk);
    check("locked", locked, e_locked);
    check("err_pulse", err_pulse, e_err);
    check("window_done", window_done, e_done);
    check("win_bits", win_bits, e_wb);
    check("win_errs", win_errs, e_we);
    if (err_pulse) n_err_obs++;
    if (window_done) begin
      n_done++; last_wb = win_bits; last_we = win_errs;
      locked_at_done = locked; locked_before_done = prev_locked;
    end
    prev_locked = locked;
  endtask

  task automatic clr_obs();
    n_err_obs = 0; n_done = 0; last_wb = 0; last_we = 0;
    locked_at_done = 0; locked_before_done = 0;
  endtask

  task automatic g_init();
    g_hist.delete();
    for (int k = 0; k < 24; k++) g_hist.push_back(1'b1);
    g_prev_tx = 0;
  endtask

  // Next channel bit from the PN generator + line encoder, optionally flipped
  task automatic src(input bit flip, output logic tx);
    bit b = 1'b0;
    bit t;
    for (int k = 0; k < int'(poly_length); k++) if (poly_taps[k]) b ^= g_hist[k];
    g_hist.push_front(b);
    void'(g_hist.pop_back());
    b ^= pcm_invert;
    case (pcm_mode)
      2'd1:    t = g_prev_tx ^ b;
      2'd2:    t = g_prev_tx ^ ~b;
      default: t = b;
    endcase
    g_prev_tx = t;
    tx = t ^ flip;
  endtask

  task automatic send(input bit flip, input int gap);
    logic tx;
    src(flip, tx);
    step(1'b1, tx, 1'b0);
    repeat (gap - 1) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    g_prev_tx = 0;
    clr_obs();
  endtask

  task automatic cfg(input logic [23:0] taps, input logic [4:0] len, input logic [1:0] mode,
                     input logic inv, input logic [31:0] win, input logic [31:0] loss);
    poly_taps = taps; poly_length = len; pcm_mode = mode; pcm_invert = inv;
    lock_thresh = 8'd32; window_bits = win; loss_thresh = loss;
    g_init();
  endtask

  task automatic run_clean(input string name);
    do_reset();
    for (int i = 1; i <= 260; i++) send(1'b0, 1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check({name, "_done_cnt"}, n_done, 1);
    check({name, "_win_errs"}, last_we, 0);
    check({name, "_win_bits"}, last_wb, 200);
    check({name, "_err_pulses"}, n_err_obs, 0);
    check({name, "_locked"}, locked, 1);
  endtask

  initial begin
    logic tx;
    reset = 1'b1; bit_en = 0; rx_bit = 0; restart = 0; prev_locked = 0;
    m_clear();

    // PN15 NRZ-L: slow lock, then a single error in a 1000-bit window
    cfg(24'h006000, 5'd15, 2'd0, 1'b0, 32'd1000, 32'd100);
    do_reset();
    check("reset_locked", locked, 0);
    check("reset_win_bits", win_bits, 0);
    check("reset_win_errs", win_errs, 0);
    for (int i = 1; i <= 1100; i++) begin
      send(i == 150, (i <= 60) ? 4 : 1);
      if (i >= 45 && i <= 48) check($sformatf("t1_lock_after_bit%0d", i), locked, i >= 47);
    end
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("t2_done_cnt", n_done, 1);
    check("t2_win_errs", last_we, 1);
    check("t2_win_bits", last_wb, 1000);
    check("t2_err_pulses", n_err_obs, 1);
    check("t2_locked", locked, 1);

    // NRZ-M: one channel flip decodes as two errors
    cfg(24'h006000, 5'd15, 2'd1, 1'b0, 32'd1000, 32'd100);
    do_reset();
    for (int i = 1; i <= 1100; i++) begin
      send(i == 150, 1);
      if (i == 47 || i == 48) check($sformatf("t3_lock_b2b_bit%0d", i), locked, i == 48);
    end
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("t3_done_cnt", n_done, 1);
    check("t3_win_errs", last_we, 2);
    check("t3_err_pulses", n_err_obs, 2);
    check("t3_locked", locked, 1);

    // Inverted PN9, then PN9 over NRZ-S
    cfg(24'h000110, 5'd9, 2'd0, 1'b1, 32'd200, 32'd100);
    run_clean("t4_inv");
    cfg(24'h000110, 5'd9, 2'd2, 1'b0, 32'd200, 32'd100);
    run_clean("t4_nrzs");

    // Loss of lock: 11 errors against a threshold of 10, then relock
    cfg(24'h006000, 5'd15, 2'd0, 1'b0, 32'd500, 32'd10);
    do_reset();
    for (int i = 1; i <= 650; i++) send(i >= 100 && i <= 110, 1);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("t5_done_cnt", n_done, 1);
    check("t5_win_errs", last_we, 11);
    check("t5_err_pulses", n_err_obs, 11);
    check("t5_locked_before_done", locked_before_done, 1);
    check("t5_locked_at_done", locked_at_done, 0);
    check("t5_relocked", locked, 1);

    // Restart coincident with bitEn while locked, then relock after N+lockThresh bits
    cfg(24'h006000, 5'd15, 2'd0, 1'b0, 32'd30, 32'd100);
    do_reset();
    for (int i = 1; i <= 100; i++) send(1'b0, 1);
    check("t6_pre_locked", locked, 1);
    check("t6_pre_win_bits", win_bits, 30);
    src(1'b0, tx);
    step(1'b1, tx, 1'b1);
    check("t6_restart_locked", locked, 0);
    check("t6_restart_win_bits", win_bits, 0);
    check("t6_restart_win_errs", win_errs, 0);
    for (int k = 1; k <= 60; k++) begin
      send(1'b0, 2);
      if (k == 46 || k == 47) check($sformatf("t6_relock_bit%0d", k), locked, k == 47);
    end
    check("t6_final_locked", locked, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
